// File: rtl/kb_pkg.sv
// kb_pkg: shared FSM state type and kb_input bit positions for the keypad scanner
package kb_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kb_state_t;
    localparam int KB_PRESSED_BIT = 7;
    localparam int KB_TOGGLE_BIT  = 6;
    localparam int KB_CODE_MSB    = 3;
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchroniser bringing the asynchronous matrix rows into clk
// Ports: clk system clock; rst async active-low reset (flops go to all-ones, i.e. no key);
//        i_d raw active-low rows; o_q synchronised rows.
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);
    logic [3:0] r_s1;
    logic [3:0] r_s2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 4'b1111;
            r_s2 <= 4'b1111;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end
    assign o_q = r_s2;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans and debounces a 4x4 active-low key matrix into the CPU kb_input byte
// Ports: clk system clock; rst async active-low reset; row_in active-low rows (async);
//        col_out active-low one-cold column drive; kb_input {PRESSED,TOGGLE,00,code};
//        key_event one-cycle pulse per accepted press.
// Build option: KB_LATCH_EN keeps the last key code in kb_input[3:0] after release.
module keypad_scanner
    import kb_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] kb_input,
    output logic       key_event
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    logic [3:0]    w_rows;
    logic          w_any;
    logic [1:0]    w_low_row;
    logic          w_row_high;
    logic [1:0]    w_col_nxt;
    kb_state_t     r_state;
    logic [1:0]    r_col;
    logic [3:0]    r_col_out;
    logic [1:0]    r_row;
    logic [DW-1:0] r_dwell;
    logic [BW-1:0] r_deb;
    logic [7:0]    r_kb;
    logic          r_key_event;
    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row_in),
        .o_q (w_rows)
    );
    assign w_any      = ~&w_rows;
    assign w_low_row  = !w_rows[0] ? 2'd0 : !w_rows[1] ? 2'd1 : !w_rows[2] ? 2'd2 : 2'd3;
    assign w_row_high = w_rows[r_row];
    assign w_col_nxt  = r_col + 2'd1;
    // The column drive is kept as its own register so col_out is a flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SCAN;
            r_col       <= 2'd0;
            r_col_out   <= 4'b1110;
            r_row       <= 2'd0;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_kb        <= 8'h00;
            r_key_event <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_dwell == DW'(SCAN_DIV - 1)) begin
                        r_dwell <= '0;
                        if (w_any) begin
                            r_row   <= w_low_row;
                            r_deb   <= '0;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col     <= w_col_nxt;
                            r_col_out <= ~(4'b0001 << w_col_nxt);
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_row_high) begin
                        r_state   <= SCAN;
                        r_deb     <= '0;
                        r_dwell   <= '0;
                        r_col     <= w_col_nxt;
                        r_col_out <= ~(4'b0001 << w_col_nxt);
                    end else if (r_deb == BW'(DEBOUNCE_CNT - 1)) begin
                        r_state                  <= PRESSED;
                        r_kb[KB_PRESSED_BIT]     <= 1'b1;
                        r_kb[KB_TOGGLE_BIT]      <= ~r_kb[KB_TOGGLE_BIT];
                        r_kb[KB_CODE_MSB:0]      <= {r_row, r_col};
                        r_key_event              <= 1'b1;
                    end else begin
                        r_deb <= r_deb + 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_row_high) begin
                        r_deb   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_row_high) begin
                        r_deb   <= '0;
                        r_state <= PRESSED;
                    end else if (r_deb == BW'(DEBOUNCE_CNT - 1)) begin
                        r_state              <= SCAN;
                        r_deb                <= '0;
                        r_dwell              <= '0;
                        r_kb[KB_PRESSED_BIT] <= 1'b0;
`ifndef KB_LATCH_EN
                        r_kb[KB_CODE_MSB:0]  <= '0;
`endif
                        r_col                <= w_col_nxt;
                        r_col_out            <= ~(4'b0001 << w_col_nxt);
                    end else begin
                        r_deb <= r_deb + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end
    assign col_out   = r_col_out;
    assign kb_input  = r_kb;
    assign key_event = r_key_event;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix-model bench with a per-cycle behavioural checker
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DC = 8;
`ifdef KB_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [7:0]  kb_input;
    logic        key_event;
    logic [15:0] keys = '0;
    logic [3:0]  exp_code = '0;
    logic [7:0]  m_kb = '0;
    logic        prev_ev = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int ev_cnt = 0;
    int held = 0;
    int rel = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .kb_input  (kb_input),
        .key_event (key_event)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_kb = 8'h00;
            prev_ev = 1'b0;
            chk("rst_kb", kb_input, 8'h00);
            chk("rst_ev", key_event, 0);
            chk("rst_col", col_out, 4'b1110);
        end else begin
            held = (keys != 0) ? held + 1 : 0;
            rel  = (keys == 0) ? rel + 1 : 0;
            chk("col_one_cold", $countones(~col_out), 1);
            if (key_event) begin
                ev_cnt++;
                chk("ev_single_cycle", prev_ev, 0);
                chk("ev_after_debounce", held >= DC, 1);
                m_kb = {1'b1, ~m_kb[6], 2'b00, exp_code};
            end else if (m_kb[7] && !kb_input[7]) begin
                chk("rel_after_debounce", rel >= DC, 1);
                m_kb = {1'b0, m_kb[6], 2'b00, LATCH ? m_kb[3:0] : 4'h0};
            end
            chk("kb_model", kb_input, m_kb);
            prev_ev = key_event;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int changes;
        logic [3:0] last;
        logic [3:0] code;
        wait_cyc(3);
        chk("reset_col", col_out, 4'b1110);
        chk("reset_kb", kb_input, 8'h00);
        chk("reset_ev", key_event, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 chk("idle_scan", col_out, 4'(~(4'b0001 << ((k / SD) % 4))));
        end
        #1;
        e0 = ev_cnt;
        exp_code = 4'd9;
        keys = 16'h1 << 9;
        wait_cyc(60);
        chk("press21_events", ev_cnt - e0, 1);
        chk("press21_kb", kb_input, 8'hC9);
        keys = '0;
        wait_cyc(12);
        chk("release21_kb", kb_input, LATCH ? 8'h49 : 8'h40);
        e0 = ev_cnt;
        exp_code = 4'd15;
        keys = 16'h1 << 15;
        for (int i = 0; i < 40 && col_out != 4'b0111; i++) wait_cyc(1);
        chk("bounce_reach_col3", col_out, 4'b0111);
        wait_cyc(6);
        keys = '0;
        changes = 0;
        last = col_out;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            if (col_out != last) changes++;
            last = col_out;
        end
        chk("bounce_no_event", ev_cnt - e0, 0);
        chk("bounce_kb", kb_input, LATCH ? 8'h49 : 8'h40);
        chk("bounce_scan_resumed", changes >= 3, 1);
        e0 = ev_cnt;
        exp_code = 4'd0;
        keys = 16'h1;
        wait_cyc(60);
        chk("press00_events", ev_cnt - e0, 1);
        chk("press00_kb", kb_input, 8'h80);
        e0 = ev_cnt;
        keys = '0;
        wait_cyc(3);
        keys = 16'h1;
        wait_cyc(20);
        chk("rebounce_no_event", ev_cnt - e0, 0);
        chk("rebounce_kb", kb_input, 8'h80);
        rst = 1'b0;
        #1;
        chk("midreset_kb", kb_input, 8'h00);
        chk("midreset_col", col_out, 4'b1110);
        chk("midreset_ev", key_event, 0);
        keys = '0;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(2);
        e0 = ev_cnt;
        exp_code = 4'd6;
        keys = (16'h1 << 6) | (16'h1 << 14);
        wait_cyc(60);
        chk("multi_events", ev_cnt - e0, 1);
        chk("multi_kb", kb_input, 8'hC6);
        keys = '0;
        wait_cyc(30);
        chk("multi_release", kb_input, LATCH ? 8'h46 : 8'h40);
        for (int it = 0; it < 12; it++) begin
            code = 4'($urandom_range(0, 15));
            e0 = ev_cnt;
            exp_code = code;
            keys = 16'h1 << code;
            wait_cyc($urandom_range(32, 60));
            chk("rand_events", ev_cnt - e0, 1);
            chk("rand_pressed", kb_input[7], 1);
            chk("rand_code", kb_input[3:0], code);
            keys = '0;
            wait_cyc($urandom_range(14, 30));
            chk("rand_released", kb_input[7], 0);
            chk("rand_rel_code", kb_input[3:0], LATCH ? code : 4'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
